wave_plotter: RTL and testbench
===============================

WAVE_PLOTTER -- requirements
Module: wave_plotter

Interface
REQ-001 SHALL have parameter H_ACTIVE, 640, visible columns and sample-buffer depth.
REQ-002 SHALL have parameter V_ACTIVE, 480, visible rows.
REQ-003 SHALL have parameter Y_MID, 240, screen row of the zero level (axis).
REQ-004 SHALL have port pixel_clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port en_shift  input  1  sample strobe; par is valid in any cycle it is high.
REQ-007 SHALL have port par  input  10  waveform sample, two's complement, -512..511.
REQ-008 SHALL have port hcount  input  10  current pixel column, 0..H_total-1.
REQ-009 SHALL have port vcount  input  10  current pixel row, 0..V_total-1.
REQ-010 SHALL have port de  input  1  high while (hcount, vcount) is inside the visible area.
REQ-011 SHALL have port pix_on  output  1  trace pixel lit.
REQ-012 SHALL have port axis_on  output  1  zero-axis pixel lit.

Function
REQ-013 SHALL store samples in a circular buffer of H_ACTIVE 10-bit entries: on en_shift, write par at wr_ptr, then advance wr_ptr; wr_ptr wraps from H_ACTIVE-1 to 0.
REQ-014 SHALL keep fill count cnt: increment on each en_shift, saturate at H_ACTIVE.
REQ-015 SHALL snapshot in the cycle where hcount==0 and vcount==0: start_ptr <= (cnt==H_ACTIVE) ? wr_ptr : 0; valid_cols <= cnt. A same-cycle en_shift is not included in the snapshot (pre-write values used).
REQ-016 SHALL read buffer address (start_ptr + hcount) mod H_ACTIVE for each visible pixel, so column 0 shows the oldest and column valid_cols-1 the newest sample.
REQ-017 SHALL, on a same-address collision between write and read, return the old (pre-write) data.
REQ-018 SHALL map sample s to row r = Y_MID - s, clamped: s > Y_MID -> r = 0; r > V_ACTIVE-1 -> r = V_ACTIVE-1.
REQ-019 SHALL assert pix_on when de, hcount < valid_cols, and vcount lies in [min(r_prev, r), max(r_prev, r)] inclusive, where r_prev is the row of column hcount-1; at hcount==0, r_prev = r.
REQ-020 SHALL assert axis_on when de and vcount==Y_MID, independent of buffer contents.
REQ-021 SHALL register both outputs with a fixed latency of exactly 2 pixel_clk cycles after the hcount/vcount/de they describe; de low yields 0 on both outputs after 2 cycles.
REQ-022 SHALL accept en_shift in any cycle, including during active video; writes during a frame may change displayed columns (no frame double-buffering).
REQ-023 SHALL ignore hcount >= H_ACTIVE for reads (outputs 0 via de low).

Reset
REQ-024 SHALL, on rst high at a clock edge, clear wr_ptr, cnt, start_ptr, valid_cols, r_prev, all pipeline registers, pix_on and axis_on to 0.
REQ-025 SHALL not clear buffer memory; stale contents stay hidden because valid_cols==0 until the next snapshot.
REQ-026 SHALL, on rst mid-frame, blank the trace from 2 cycles after the reset edge through the next snapshot; axis_on resumes 2 cycles after rst falls.
REQ-027 SHALL give rst priority over a simultaneous en_shift (sample discarded).

Verification
REQ-028 SHALL test reset: rst for 2 cycles mid-frame with de=1 at vcount=240 -> pix_on=0, axis_on=0 while in reset; axis_on=1 again 2 cycles after rst falls.
REQ-029 SHALL test a constant trace: 640 strobes of par=100, then a frame -> pix_on=1 only at vcount=140 for hcount 0..639; axis_on=1 only at vcount=240.
REQ-030 SHALL test a partial fill: 10 strobes of par=0, then a frame -> pix_on at vcount=240 for hcount 0..9, none for hcount>=10.
REQ-031 SHALL test wrap and scroll: 645 strobes with par=n (n = 0..644, sign-extended, clamped) -> column 0 shows sample 5 (row 235) and column 639 shows sample 644 (row 0 after clamp).
REQ-032 SHALL test clamp and vertical connection: samples 300 then -300 -> column 0 lit only at row 0; column 1 lit on rows 0..479 inclusive.
REQ-033 SHALL test latency and collision: check pix_on exactly 2 cycles after its pixel; en_shift at the read address during display -> old value is shown.

Source files
------------

// File: rtl/wave_plotter.sv
//------------------------------------------------------------------------------
// Module : wave_plotter
// Brief  : Scrolling oscilloscope trace over a circular sample buffer, 2-cycle
//          registered pixel output with vertical segment joining.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wave_plotter #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int Y_MID    = 240
) (
    input  logic       pixel_clk,
    input  logic       rst,
    input  logic       en_shift,
    input  logic [9:0] par,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic       de,
    output logic       pix_on,
    output logic       axis_on
);

    localparam int AW = $clog2(H_ACTIVE);
    localparam int CW = $clog2(H_ACTIVE + 1);
    localparam logic signed [11:0] c_ymid = 12'(Y_MID);
    localparam logic signed [11:0] c_vmax = 12'(V_ACTIVE - 1);

    logic [9:0]    r_mem [H_ACTIVE];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_start_ptr;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_valid_cols;

    // stage 1 registers
    logic [9:0]    r_data;
    logic [9:0]    r_vc;
    logic          r_de;
    logic          r_in;
    logic          r_first;

    // stage 2 state
    logic [9:0]    r_prev_row;

    logic          w_snap;
    logic [AW-1:0] w_start;
    logic [CW-1:0] w_valid;
    logic [11:0]   w_sum;
    logic [AW-1:0] w_addr;
    logic signed [11:0] w_samp;
    logic signed [11:0] w_diff;
    logic [9:0]    w_row;
    logic [9:0]    w_prev;
    logic [9:0]    w_lo;
    logic [9:0]    w_hi;

    // The snapshot is forwarded so the frame's first pixel already uses it.
    assign w_snap  = (hcount == 10'd0) && (vcount == 10'd0);
    assign w_start = w_snap ? ((r_cnt == CW'(H_ACTIVE)) ? r_wr_ptr : '0) : r_start_ptr;
    assign w_valid = w_snap ? r_cnt : r_valid_cols;
    assign w_sum   = 12'(w_start) + 12'(hcount);

    always_comb begin
        w_addr = '0;
        if (12'(hcount) < 12'(H_ACTIVE)) begin
            if (w_sum >= 12'(H_ACTIVE)) begin
                w_addr = AW'(w_sum - 12'(H_ACTIVE));
            end else begin
                w_addr = AW'(w_sum);
            end
        end
    end

    assign w_samp = {{2{r_data[9]}}, r_data};
    assign w_diff = c_ymid - w_samp;

    always_comb begin
        if (w_diff < 12'sd0) begin
            w_row = '0;
        end else if (w_diff > c_vmax) begin
            w_row = 10'(V_ACTIVE - 1);
        end else begin
            w_row = w_diff[9:0];
        end
    end

    assign w_prev = r_first ? w_row : r_prev_row;
    assign w_lo   = (w_prev < w_row) ? w_prev : w_row;
    assign w_hi   = (w_prev < w_row) ? w_row : w_prev;

    // Buffer is never cleared; valid_cols hides stale contents after reset.
    always_ff @(posedge pixel_clk) begin
        if (en_shift && !rst) begin
            r_mem[r_wr_ptr] <= par;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_cnt        <= '0;
            r_start_ptr  <= '0;
            r_valid_cols <= '0;
            r_data       <= '0;
            r_vc         <= '0;
            r_de         <= 1'b0;
            r_in         <= 1'b0;
            r_first      <= 1'b0;
            r_prev_row   <= '0;
            pix_on       <= 1'b0;
            axis_on      <= 1'b0;
        end else begin
            if (en_shift) begin
                if (r_wr_ptr == AW'(H_ACTIVE - 1)) begin
                    r_wr_ptr <= '0;
                end else begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (r_cnt != CW'(H_ACTIVE)) begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
            if (w_snap) begin
                r_start_ptr  <= w_start;
                r_valid_cols <= w_valid;
            end

            r_data  <= r_mem[w_addr];
            r_vc    <= vcount;
            r_de    <= de && (12'(hcount) < 12'(H_ACTIVE));
            r_in    <= 11'(hcount) < 11'(w_valid);
            r_first <= (hcount == 10'd0);

            r_prev_row <= w_row;
            pix_on     <= r_de && r_in && (r_vc >= w_lo) && (r_vc <= w_hi);
            axis_on    <= r_de && (r_vc == 10'(Y_MID));
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wave_plotter.sv
//------------------------------------------------------------------------------
// Module : tb_wave_plotter
// Brief  : Randomized self-checking bench for wave_plotter against a sample
//          history model.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_wave_plotter;

    localparam int H  = 640;
    localparam int V  = 480;
    localparam int YM = 240;

    logic       pixel_clk = 1'b0;
    logic       rst       = 1'b1;
    logic       en_shift  = 1'b0;
    logic       de        = 1'b0;
    logic [9:0] par       = '0;
    logic [9:0] hcount    = '0;
    logic [9:0] vcount    = '0;
    logic       pix_on;
    logic       axis_on;

    wave_plotter #(.H_ACTIVE(H), .V_ACTIVE(V), .Y_MID(YM)) dut (
        .pixel_clk (pixel_clk),
        .rst       (rst),
        .en_shift  (en_shift),
        .par       (par),
        .hcount    (hcount),
        .vcount    (vcount),
        .de        (de),
        .pix_on    (pix_on),
        .axis_on   (axis_on)
    );

    always #5 pixel_clk = ~pixel_clk;

    typedef struct {
        bit pix;
        bit axis;
        int h;
        int v;
    } exp_t;

    int   n_total = 0;
    int   n_bad   = 0;
    int   hist[$];          // every sample written since the last reset
    int   snap_vis  = 0;
    int   snap_base = 0;
    int   m_prev_row = 0;
    exp_t exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_total++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, expv);
        end
    endtask

    function automatic int row_of(input int s);
        int r;
        r = YM - s;
        if (r < 0) r = 0;
        if (r > V - 1) r = V - 1;
        return r;
    endfunction

    // One pixel clock: predict, drive, advance the model, compare the output
    // that belongs to the previous call (2-cycle latency).
    task automatic tick(input bit r, input int h, input int v, input bit d,
                        input bit e, input int p);
        exp_t ent;
        int   idx, w, j, rc, rp, lo, hi;
        ent.pix = 0; ent.axis = 0; ent.h = h; ent.v = v;
        if (!r) begin
            if (h == 0 && v == 0) begin
                snap_vis  = (hist.size() >= H) ? H : hist.size();
                snap_base = (hist.size() >= H) ? hist.size() - H : 0;
            end
            if (d && h < H) begin
                ent.axis = (v == YM);
                if (h < snap_vis) begin
                    idx = snap_base + h;
                    w   = hist.size();
                    j   = idx + H * ((w - 1 - idx) / H);
                    rc  = row_of(hist[j]);
                    rp  = (h == 0) ? rc : m_prev_row;
                    lo  = (rp < rc) ? rp : rc;
                    hi  = (rp < rc) ? rc : rp;
                    ent.pix    = (v >= lo) && (v <= hi);
                    m_prev_row = rc;
                end
            end
        end
        exp_q.push_back(ent);
        rst      = r;
        hcount   = 10'(h);
        vcount   = 10'(v);
        de       = d;
        en_shift = e;
        par      = 10'(p);
        @(posedge pixel_clk);
        #1;
        if (r) begin
            hist.delete();
            snap_vis  = 0;
            snap_base = 0;
            foreach (exp_q[i]) begin
                exp_q[i].pix  = 0;
                exp_q[i].axis = 0;
            end
        end else if (e) begin
            hist.push_back(int'($signed(10'(p))));
        end
        if (exp_q.size() >= 2) begin
            ent = exp_q.pop_front();
            check_eq($sformatf("pix h%0d v%0d", ent.h, ent.v), 32'(pix_on), 32'(ent.pix));
            check_eq($sformatf("axis h%0d v%0d", ent.h, ent.v), 32'(axis_on), 32'(ent.axis));
        end
    endtask

    task automatic blank(input int n);
        repeat (n) tick(0, 700, 500, 0, 0, 0);
    endtask

    task automatic strobe(input int s);
        tick(0, 700, 500, 0, 1, s);
    endtask

    task automatic do_reset(input int n);
        repeat (n) tick(1, 700, 500, 0, 0, 0);
    endtask

    task automatic scan_row(input int v, input int ncols, input int shift_rate);
        bit e;
        for (int c = 0; c < ncols; c++) begin
            e = (shift_rate > 0) && ($urandom_range(shift_rate - 1) == 0);
            tick(0, c, v, 1, e, int'($urandom_range(0, 1023)) - 512);
        end
        for (int c = 640; c < 648; c++) tick(0, c, v, 0, 0, 0);
    endtask

    initial begin
        // reset state and mid-frame reset with the axis visible
        do_reset(3);
        blank(2);
        for (int c = 0; c < 10; c++) tick(0, c, YM, 1, 0, 0);
        tick(1, 10, YM, 1, 0, 0);
        tick(1, 11, YM, 1, 0, 0);
        for (int c = 12; c < 20; c++) tick(0, c, YM, 1, 0, 0);
        blank(3);

        // constant trace
        do_reset(2);
        repeat (H) strobe(100);
        scan_row(0, H, 0);
        scan_row(139, H, 0);
        scan_row(140, H, 0);
        scan_row(141, H, 0);
        scan_row(YM, H, 0);
        scan_row(479, H, 0);

        // partial fill
        do_reset(2);
        repeat (10) strobe(0);
        scan_row(0, 30, 0);
        scan_row(YM, 30, 0);
        scan_row(YM - 1, 30, 0);

        // wrap and scroll, samples clamped to the signed range
        do_reset(2);
        for (int n = 0; n < 645; n++) strobe((n > 511) ? 511 : n);
        scan_row(0, H, 0);
        scan_row(235, H, 0);
        scan_row(479, H, 0);

        // clamp and vertical connection
        do_reset(2);
        strobe(300);
        strobe(-300);
        scan_row(0, 6, 0);
        scan_row(1, 6, 0);
        scan_row(YM, 6, 0);
        scan_row(478, 6, 0);
        scan_row(479, 6, 0);

        // collision: write lands on the address being read at column 0
        do_reset(2);
        repeat (H) strobe(100);
        scan_row(0, H, 0);
        tick(0, 0, 140, 1, 1, -200);
        for (int c = 1; c < H; c++) tick(0, c, 140, 1, 0, 0);
        blank(4);
        scan_row(0, H, 0);
        scan_row(300, H, 0);

        // randomized frames with strobes during active video
        do_reset(2);
        for (int it = 0; it < 15; it++) begin
            repeat ($urandom_range(0, 700)) strobe(int'($urandom_range(0, 1023)) - 512);
            scan_row(0, $urandom_range(1, H), 8);
            repeat (3) scan_row($urandom_range(0, V - 1), H, 12);
            if ($urandom_range(0, 4) == 0) do_reset($urandom_range(1, 3));
        end
        blank(4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
